serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Sequencer that time-shares a single one-bit full_adder to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Operands are accepted through a valid/ready input handshake; the sum is presented through a valid/ready output handshake.
- Area-minimal arithmetic unit for the ALU chapter datapath: one full adder plus shift registers instead of a WIDTH-bit ripple chain.

Parameters:
WIDTH, 16, operand and sum width in bits (>= 2)
CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin present
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  sum, cout, ovf valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high in RUN

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE; in_ready = 1 (state-decoded)
  - out_valid = 0, busy = 0
  - sum = 0, cout = 0, ovf = 0
  - internal shift registers, carry and counter = 0
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=0, RUN=1, DONE=2. Value 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1: load a_sr=a, b_sr=b, carry=cin, cnt=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN (per edge):
  - The full_adder computes s, c from a_sr[0], b_sr[0], carry.
  - s is shifted into the MSB of sum_sr; a_sr and b_sr shift right by 1.
  - carry is updated to c; cnt is incremented.
  - On the edge where cnt == WIDTH-1:
    - latch c into cout;
    - set ovf = c XOR (carry value before this edge);
    - go to DONE.
  - in_valid is ignored while in RUN.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - On an edge with out_ready=1: go to IDLE.
  - in_ready = 0 in DONE, so no new start is accepted on the same edge as the result handoff.
- Latency:
  - The accept edge is edge 0. out_valid is visible after edge WIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum issue interval is WIDTH+2 cycles.
- Result outputs change only on the edge entering DONE; they hold their value through IDLE until the next result.
- Wrap-around: the counter saturates logically via the state change. The sum is modulo 2^WIDTH.
- If rst_n is asserted in RUN or DONE, the operation is aborted immediately:
  - all outputs go to their reset values;
  - the result is lost;
  - no out_valid is issued.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled on the accept edge.
  - When sub=1, b is loaded inverted and the carry is loaded as 1, ignoring cin. sum = a - b; cout = 1 means no borrow.
  - ovf uses the same MSB rule.
- Undefined: port absent; pure addition.

Decomposition:
- Shared header serial_adder_defs.vh holds:
  - state encodings ST_IDLE, ST_RUN, ST_DONE;
  - default width constant WORD_W = 16.
- The single sub-module is the existing full_adder, instantiated once. No other hierarchy.

Test Plan:
- WIDTH=16, a=0x0003, b=0x0005, cin=0 -> out_valid 16 cycles after accept; sum=0x0008, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/out_valid stable, in_ready=0. Pulse in_valid during RUN -> ignored; result unchanged.
- Reset mid-op: drop rst_n at cycle 7 of RUN -> busy=0, out_valid=0, sum=0 immediately. After release, a new op 0x1234+0x1111 -> 0x2345.
- With SERIAL_ADDER_SUB_EN: sub=1, a=5, b=3 -> sum=0x0002, cout=1. a=3, b=5 -> sum=0xFFFE, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer: state encoding and default word width.
package serial_adder_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`endif

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder shared by the serial adder sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a sub input (a - b via inverted b and carry-in of 1).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | in_ready high, waiting for operands
//   ST_RUN  | adding one bit per edge, busy high
//   ST_DONE | out_valid high, result held until out_ready
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic             carry, cout_q, ovf_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_s, fa_c, last, sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last)          state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // a_sr doubles as the sum shift register: sum bits enter at the MSB as operand bits leave the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= sub_sel ? ~bus.b : bus.b;
                        carry <= sub_sel ? 1'b1 : bus.cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr  <= {fa_s, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        sum_q  <= {fa_s, a_sr[WIDTH-1:1]};
                        cout_q <= fa_c;
                        ovf_q  <= fa_c ^ carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, result scoreboard, corner-case sequences.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive_ops(input vec_t v);
        bus.a   = v.a;
        bus.b   = v.b;
        bus.cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = v.sub;
`endif
    endtask

    task automatic do_op(input vec_t v, input int hold, input bit pulse);
        int   lat;
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        drive_ops(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{v.sum, v.cout, v.ovf});
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_run", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < WIDTH + 4) begin
            if (pulse && lat == 3) begin
                bus.in_valid = 1'b1;
                bus.a = 16'hDEAD;
                bus.b = 16'hBEEF;
                check("in_ready_run", 32'(bus.in_ready), 32'd0);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(lat), 32'(WIDTH));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum", 32'(bus.sum), 32'(e.sum));
            @(posedge clk);
            @(negedge clk);
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after", 32'(bus.out_valid), 32'd0);
        check("in_ready_after", 32'(bus.in_ready), 32'd1);
        check("sum_held_idle", 32'(bus.sum), 32'(e.sum));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        //           a         b         cin   sub   sum       cout  ovf
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        #12;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i], 0, 1'b0);

        // Backpressure for 5 cycles, then a stray in_valid pulse during RUN.
        do_op(vecs[0], 5, 1'b0);
        do_op(vecs[3], 0, 1'b1);

        // Leave a non-zero result behind, then abort an op mid-RUN with reset.
        do_op(vecs[6], 0, 1'b0);
        @(negedge clk);
        drive_ops(vecs[8]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{vecs[8].sum, vecs[8].cout, vecs[8].ovf});
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("no_out_valid_after_abort", 32'(seen), 32'd0);
        do_op(vecs[8], 0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
